// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helper for the arithmetic datapath
// Contents: state_t (IDLE/CALC/FIN encoding), cnt_w() iteration-counter width.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Counter must hold 0..b_w-1; keep at least one bit for tiny multipliers.
  function automatic int cnt_w(input int b_w);
    return (b_w <= 2) ? 1 : $clog2(b_w);
  endfunction

endpackage

// File: rtl/addsub_n.sv
// rtl/addsub_n.sv - N-bit ripple-carry adder/subtractor
// Ports: a, b (N-bit operands), m (0 = a+b, 1 = a-b), s (N-bit result), c (carry out).
module addsub_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         m,
  output logic [N-1:0] s,
  output logic         c
);

  // Subtraction is a + ~b + 1: invert b and seed the carry chain with m.
  always_comb begin : ripple
    logic cy;
    logic bx;
    cy = m;
    bx = 1'b0;
    s  = '0;
    for (int i = 0; i < N; i++) begin
      bx   = b[i] ^ m;
      s[i] = a[i] ^ bx ^ cy;
      cy   = (a[i] & bx) | (cy & (a[i] ^ bx));
    end
    c = cy;
  end

endmodule

// File: rtl/seq_mul_shift_add.sv
// rtl/seq_mul_shift_add.sv - sequential shift-and-add multiplier, signed/unsigned per operation
// Ports: clk, rst_n (async active-low), start, signed_mode, A (A_W), B (B_W) in;
//        busy, done (one-cycle pulse), P (A_W+B_W product, held until next done) out.
module seq_mul_shift_add
  import arith_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] P
);

  localparam int P_W = A_W + B_W;
  localparam int C_W = cnt_w(B_W);
  localparam logic [C_W-1:0] CNT_LAST = C_W'(B_W - 1);

  state_t state, state_nxt;

  logic [A_W-1:0] mag_a;
  logic [A_W-1:0] acc;
  logic [B_W-1:0] mag_b;   // multiplier magnitude; low half of the product shifts in here
  logic [C_W-1:0] cnt;
  logic           neg;

  logic [A_W-1:0] neg_a;
  logic [B_W-1:0] neg_b;
  logic [A_W-1:0] add_b;
  logic [A_W-1:0] sum;
  logic           carry;
  logic [P_W-1:0] prod;
  logic [P_W-1:0] prod_neg;
  logic           abs_a_c_unused;
  logic           abs_b_c_unused;
  logic           neg_c_unused;

  addsub_n #(.N(A_W)) u_abs_a (
    .a('0), .b(A), .m(1'b1), .s(neg_a), .c(abs_a_c_unused)
  );

  addsub_n #(.N(B_W)) u_abs_b (
    .a('0), .b(B), .m(1'b1), .s(neg_b), .c(abs_b_c_unused)
  );

  // Gating the addend instead of the sum keeps the shift path identical every cycle.
  assign add_b = mag_b[0] ? mag_a : '0;

  addsub_n #(.N(A_W)) u_acc (
    .a(acc), .b(add_b), .m(1'b0), .s(sum), .c(carry)
  );

  assign prod = {acc, mag_b};

  // 0 - 0 is 0, so a zero magnitude never turns into a nonzero result.
  addsub_n #(.N(P_W)) u_neg (
    .a('0), .b(prod), .m(1'b1), .s(prod_neg), .c(neg_c_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          // Magnitudes are unsigned, so the most-negative operand maps cleanly to 2^(W-1).
          mag_a <= (signed_mode && A[A_W-1]) ? neg_a : A;
          mag_b <= (signed_mode && B[B_W-1]) ? neg_b : B;
          neg   <= signed_mode & (A[A_W-1] ^ B[B_W-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        ST_CALC: begin
          acc   <= {carry, sum[A_W-1:1]};
          mag_b <= {sum[0], mag_b[B_W-1:1]};
          cnt   <= cnt + C_W'(1);
        end
        ST_FIN: begin
          P    <= neg ? prod_neg : prod;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
